// File: rtl/refresh_engine.sv
// Periodic array refresh sequencer: walks the rows a scoreboard offers, reads each
// one and writes it back through a 4-entry FIFO that always yields to user writes.
module refresh_engine #(
  parameter int DATA_W         = 16,
  parameter int REFRESH_PERIOD = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sr_done,
  input  logic [6:0]        sr_addr_ref,
  input  logic              sr_indicator_ref,
  input  logic              user_rd_en,
  input  logic [6:0]        user_rd_addr,
  input  logic              user_wr_en,
  input  logic [6:0]        user_wr_addr,
  input  logic [DATA_W-1:0] arr_rd_data,
  output logic              sr_start,
  output logic              arr_rd_en,
  output logic [6:0]        arr_rd_addr,
  output logic              arr_wr_en,
  output logic [6:0]        arr_wr_addr,
  output logic [DATA_W-1:0] arr_wr_data,
  output logic              refresh_busy,
  output logic              fifo_overflow,
  output logic              refresh_overdue,
  output logic [15:0]       sweep_count
);

  // state | meaning
  // IDLE  | waiting for the period timer or a pending expiry
  // START | one-cycle sr_start pulse to the scoreboard
  // ARM   | scoreboard settling cycle, no reads, sr_done ignored
  // SWEEP | reading offered rows and queueing their write-backs
  // DRAIN | sweep finished, emptying the write-back FIFO
  typedef enum logic [2:0] {IDLE, START, ARM, SWEEP, DRAIN} state_t;

  localparam int TMR_W = (REFRESH_PERIOD > 2) ? $clog2(REFRESH_PERIOD) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_PERIOD - 1);

  state_t            state, state_nxt;
  logic [TMR_W-1:0]  tmr;
  logic              tmr_expire;
  logic              expiry_pend;
  logic              eng_rd;
  logic              sched;
  logic [6:0]        sched_addr;
  logic              sweep_end;

  logic              push_pend;
  logic [6:0]        push_addr;
  logic              push_hit;
  logic              push_ok;
  logic              push_drop;
  logic              fifo_pop;

  logic [6:0]        fifo_addr [4];
  logic [DATA_W-1:0] fifo_data [4];
  logic [3:0]        fifo_vld;
  logic [1:0]        rd_ptr, wr_ptr;
  logic [2:0]        fifo_cnt;

  assign tmr_expire = (tmr == TMR_LAST);

  always_comb begin
    state_nxt    = state;
    sr_start     = 1'b0;
    refresh_busy = 1'b1;
    eng_rd       = 1'b0;
    sched        = 1'b0;
    sched_addr   = '0;
    sweep_end    = 1'b0;
    case (state)
      IDLE: begin
        refresh_busy = 1'b0;
        if (tmr_expire || expiry_pend) state_nxt = START;
      end
      START: begin
        sr_start  = 1'b1;
        state_nxt = ARM;
      end
      ARM: state_nxt = SWEEP;
      SWEEP: begin
        // a user read already fetches the row, so it is written back instead
        if (user_rd_en) begin
          sched      = 1'b1;
          sched_addr = user_rd_addr;
        end else if (!sr_done && !sr_indicator_ref) begin
          eng_rd     = 1'b1;
          sched      = 1'b1;
          sched_addr = sr_addr_ref;
        end
        if (sr_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        if ((fifo_cnt == 3'd0) && !push_pend) begin
          state_nxt = IDLE;
          sweep_end = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign arr_rd_en   = eng_rd;
  assign arr_rd_addr = eng_rd ? sr_addr_ref : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      tmr             <= '0;
      expiry_pend     <= 1'b0;
      refresh_overdue <= 1'b0;
      sweep_count     <= '0;
      push_pend       <= 1'b0;
      push_addr       <= '0;
    end else begin
      state     <= state_nxt;
      push_pend <= sched;
      push_addr <= sched_addr;
      if (state_nxt == START) tmr <= '0;
      else if (tmr_expire)    tmr <= '0;
      else                    tmr <= tmr + TMR_W'(1);
      if (tmr_expire && (state != IDLE)) begin
        expiry_pend     <= 1'b1;
        refresh_overdue <= 1'b1;
      end else if ((state == IDLE) && (state_nxt == START)) begin
        expiry_pend <= 1'b0;
      end
      if (sweep_end) sweep_count <= sweep_count + 16'd1;
    end
  end

  // the entry pushed this cycle is not yet visible to the pop side
  assign fifo_pop  = !user_wr_en && (fifo_cnt != 3'd0);
  assign push_hit  = user_wr_en && (user_wr_addr == push_addr);
  assign push_ok   = push_pend && ((fifo_cnt != 3'd4) || fifo_pop);
  assign push_drop = push_pend && !push_ok;

  assign arr_wr_en   = fifo_pop && fifo_vld[rd_ptr];
  assign arr_wr_addr = arr_wr_en ? fifo_addr[rd_ptr] : '0;
  assign arr_wr_data = arr_wr_en ? fifo_data[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_vld      <= '0;
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      fifo_cnt      <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (user_wr_en) begin
        for (int i = 0; i < 4; i++) begin
          if (fifo_addr[i] == user_wr_addr) fifo_vld[i] <= 1'b0;
        end
      end
      if (push_ok) begin
        fifo_vld[wr_ptr] <= !push_hit;
        wr_ptr           <= wr_ptr + 2'd1;
      end
      if (fifo_pop) rd_ptr <= rd_ptr + 2'd1;
      fifo_cnt <= fifo_cnt + {2'b00, push_ok} - {2'b00, fifo_pop};
      if (push_drop) fifo_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= arr_rd_data;
    end
  end

endmodule
